// File: rtl/mux_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sched_pkg
//  Description : Shared constants and state encoding for the round-robin
//                mux scheduler and its priority-scan helper.
//  Contents    : N_REQ   - number of requesters sharing the mux
//                SEL_W   - width of the mux select / requester index
//                state_t - scheduler state encoding (IDLE / GRANT)
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational wrap-around priority scan. Returns the first
//                set request bit found scanning ptr, ptr+1, ..., 7, 0, ...,
//                ptr-1.
//  Ports       : req [7:0] in  - request vector
//                ptr [2:0] in  - starting position of the scan
//                idx [2:0] out - index of the first set bit (ptr when none)
//                any       out - at least one request bit is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] w_pos;

  // Scan from the farthest offset back toward ptr so that the closest set
  // bit (smallest offset from ptr) is the last one written and wins.
  // The position arithmetic wraps naturally in SEL_W bits.
  always_comb begin
    idx   = ptr;
    any   = |req;
    w_pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = ptr + SEL_W'(k);
      if (req[w_pos]) begin
        idx = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_scheduler
//  Description : Round-robin scheduler sharing one 8:1 single-bit data mux
//                among 8 requesters, with a valid/ready handshake toward a
//                single consumer. Each grant is limited to MAX_BURST
//                accepted transfers before the grant rotates.
//  Ports       : clk           in  - rising-edge clock
//                rst           in  - synchronous active-high reset
//                req [7:0]     in  - request vector, bit i = requester i
//                in  [7:0]     in  - data bits, in[i] belongs to requester i
//                out_ready     in  - consumer accepts out this cycle
//                sel [2:0]     out - registered mux select (grantee index)
//                gnt [7:0]     out - registered one-hot grant, zero if idle
//                out           out - in[sel] through the shared mux
//                out_valid     out - grant active and grantee requesting
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             out,
  output logic             out_valid
);

  // Burst count value at which the next accepted transfer ends the grant.
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_nxt;

  logic [SEL_W-1:0] w_pick_ptr;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_xfer;
  logic             w_release;

  // A single scanner serves both cases: from the stored pointer when idle,
  // and from the position after the current grantee when a grant releases.
  // Starting after the grantee makes it the last candidate, so it is only
  // regranted when nobody else is requesting.
  assign w_pick_ptr = (r_state == ST_IDLE) ? r_ptr : (r_sel + SEL_W'(1));

  rr_pick u_rr_pick (
    .req (req),
    .ptr (w_pick_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  // Shared 8:1 data mux.
  assign out = in[r_sel];

  assign out_valid = (r_gnt != '0) && req[r_sel];
  assign w_xfer    = out_valid && out_ready;
  assign w_release = !req[r_sel] || (w_xfer && (r_burst_cnt == C_LAST_BEAT));

  assign sel = r_sel;
  assign gnt = r_gnt;

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_gnt_nxt       = r_gnt;
    w_ptr_nxt       = r_ptr;
    w_burst_cnt_nxt = r_burst_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_sel_nxt       = w_pick_idx;
          w_gnt_nxt       = N_REQ'(1) << w_pick_idx;
          w_burst_cnt_nxt = '0;
          w_state_nxt     = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = r_sel + SEL_W'(1);
          if (w_pick_any) begin
            // Back-to-back regrant, no idle bubble.
            w_sel_nxt       = w_pick_idx;
            w_gnt_nxt       = N_REQ'(1) << w_pick_idx;
            w_burst_cnt_nxt = '0;
          end else begin
            w_gnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_xfer) begin
          w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_gnt       <= w_gnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_rr_scheduler
//  Description : Self-checking bench for mux_rr_scheduler. A behavioural
//                reference model tracks the current owner, rotation pointer
//                and number of accepted transfers in the current grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_scheduler;

  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] in;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       out;
  logic       out_valid;

  always #5 clk = ~clk;

  mux_rr_scheduler #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in        (in),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_cnt;

  // Expected outputs for the inputs currently applied
  logic [7:0] e_gnt;
  logic [2:0] e_sel;
  logic       e_valid;
  logic       e_out;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return 0;
  endfunction

  // Drive inputs (called just after a falling edge) and derive expectations.
  task automatic apply(input logic [7:0] r, input logic [7:0] d,
                       input logic rdy, input logic rs);
    req       = r;
    in        = d;
    out_ready = rdy;
    rst       = rs;
    #1;
    e_sel   = 3'(m_sel);
    e_gnt   = m_busy ? (8'd1 << m_sel) : 8'd0;
    e_valid = m_busy && req[m_sel];
    e_out   = in[m_sel];
  endtask

  // Advance one clock and update the model with the applied inputs.
  task automatic step();
    bit xfer;
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_sel  = 0;
      m_ptr  = 0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (req != 8'h00) begin
        m_sel  = pick(req, m_ptr);
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      xfer = req[m_sel] && out_ready;
      if (xfer) m_cnt++;
      if (!req[m_sel] || (xfer && m_cnt == MAX_BURST)) begin
        m_ptr = (m_sel + 1) % 8;
        if (req != 8'h00) begin
          m_sel = pick(req, m_ptr);
          m_cnt = 0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply(8'h00, 8'h00, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      apply(8'h00, 8'($urandom), 1'b1, 1'b0);
      vectors++;
      if ({sel, gnt, out_valid, out} !== {3'd0, 8'h00, 1'b0, in[0]}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: sel/gnt/valid/out got %0d/%h/%b/%b expected 0/00/0/%b",
                 i, sel, gnt, out_valid, out, in[0]);
      end
      step();
    end
  endtask

  task automatic test_single();
    apply(8'h00, 8'h00, 1'b0, 1'b1);
    step();
    apply(8'h20, 8'b1111_0001, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      apply(8'h20, 8'b1111_0001, 1'b1, 1'b0);
      vectors++;
      if ({sel, gnt, out_valid, out} !== {3'd5, 8'h20, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL single cyc %0d: sel/gnt/valid/out got %0d/%h/%b/%b expected 5/20/1/1",
                 i, sel, gnt, out_valid, out);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    int exp_owner;
    apply(8'h00, 8'h00, 1'b0, 1'b1);
    step();
    apply(8'hFF, 8'($urandom), 1'b1, 1'b0);
    step();
    for (int i = 0; i < 36; i++) begin
      apply(8'hFF, 8'($urandom), 1'b1, 1'b0);
      exp_owner = (i / MAX_BURST) % 8;
      vectors++;
      if ({sel, gnt, out_valid, out} !== {3'(exp_owner), 8'd1 << exp_owner, 1'b1, in[exp_owner]}) begin
        errors++;
        $display("FAIL round_robin cyc %0d: sel/gnt/valid got %0d/%h/%b expected %0d/%h/1",
                 i, sel, gnt, out_valid, exp_owner, 8'd1 << exp_owner);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic rdy;
    apply(8'h00, 8'h00, 1'b0, 1'b1);
    step();
    apply(8'h18, 8'($urandom), 1'b1, 1'b0);
    step();
    // 1 transfer, 10 stalled cycles, then 3 transfers finish the burst.
    for (int i = 0; i < 14; i++) begin
      rdy = (i == 0 || i >= 11);
      apply(8'h18, 8'($urandom), rdy, 1'b0);
      vectors++;
      if ({sel, gnt, out_valid} !== {3'd3, 8'h08, 1'b1}) begin
        errors++;
        $display("FAIL backpressure cyc %0d: sel/gnt/valid got %0d/%h/%b expected 3/08/1",
                 i, sel, gnt, out_valid);
      end
      step();
    end
    apply(8'h18, 8'($urandom), 1'b1, 1'b0);
    vectors++;
    if ({sel, gnt} !== {3'd4, 8'h10}) begin
      errors++;
      $display("FAIL backpressure_rotate: sel/gnt got %0d/%h expected 4/10", sel, gnt);
    end
    step();
  endtask

  task automatic test_early_release_wrap();
    apply(8'h00, 8'h00, 1'b0, 1'b1);
    step();
    apply(8'h80, 8'h80, 1'b1, 1'b0);
    step();
    apply(8'h81, 8'h80, 1'b1, 1'b0);
    vectors++;
    if ({sel, gnt, out_valid, out} !== {3'd7, 8'h80, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL early_grant7: sel/gnt/valid/out got %0d/%h/%b/%b expected 7/80/1/1",
               sel, gnt, out_valid, out);
    end
    step();
    apply(8'h01, 8'h80, 1'b1, 1'b0);
    vectors++;
    if ({gnt, out_valid} !== {8'h80, 1'b0}) begin
      errors++;
      $display("FAIL early_drop: gnt/valid got %h/%b expected 80/0", gnt, out_valid);
    end
    step();
    apply(8'h03, 8'h01, 1'b1, 1'b0);
    vectors++;
    if ({sel, gnt, out_valid, out} !== {3'd0, 8'h01, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL early_wrap: sel/gnt/valid/out got %0d/%h/%b/%b expected 0/01/1/1",
               sel, gnt, out_valid, out);
    end
    step();
  endtask

  task automatic test_reset_mid_grant();
    apply(8'h00, 8'h00, 1'b0, 1'b1);
    step();
    // Full burst for 2 moves the pointer to 3, then 2 is regranted alone.
    for (int i = 0; i < 5; i++) begin
      apply(8'h04, 8'($urandom), 1'b1, 1'b0);
      step();
    end
    apply(8'h0C, 8'($urandom), 1'b1, 1'b1);
    vectors++;
    if (gnt !== 8'h04) begin
      errors++;
      $display("FAIL midreset_before: gnt got %h expected 04", gnt);
    end
    step();
    apply(8'h0C, 8'($urandom), 1'b1, 1'b0);
    vectors++;
    if ({sel, gnt, out_valid} !== {3'd0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midreset_after: sel/gnt/valid got %0d/%h/%b expected 0/00/0",
               sel, gnt, out_valid);
    end
    step();
    apply(8'h0C, 8'($urandom), 1'b1, 1'b0);
    vectors++;
    if ({sel, gnt} !== {3'd2, 8'h04}) begin
      errors++;
      $display("FAIL midreset_ptr: sel/gnt got %0d/%h expected 2/04", sel, gnt);
    end
    step();
  endtask

  task automatic test_random();
    logic [7:0] r;
    apply(8'h00, 8'h00, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      apply(r, 8'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 59) == 0));
      vectors++;
      if ({sel, gnt, out_valid, out} !== {e_sel, e_gnt, e_valid, e_out}) begin
        errors++;
        $display("FAIL random cyc %0d: sel/gnt/valid/out got %0d/%h/%b/%b expected %0d/%h/%b/%b",
                 i, sel, gnt, out_valid, out, e_sel, e_gnt, e_valid, e_out);
      end
      step();
    end
  endtask

  initial begin
    req       = 8'h00;
    in        = 8'h00;
    out_ready = 1'b0;
    rst       = 1'b1;
    m_busy    = 1'b0;
    m_sel     = 0;
    m_ptr     = 0;
    m_cnt     = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_release_wrap();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8:1 single-bit data mux (`out = in[sel]`) among 8 requesters.
- Each requester raises `req[i]` while its data bit `in[i]` is valid.
- The scheduler drives the mux select, a one-hot grant and a valid/ready handshake toward a single downstream consumer.
- Fairness: each grant is bounded to a burst of at most MAX_BURST accepted transfers.

Parameters:
- MAX_BURST, 4, maximum accepted transfers per grant before forced rotation (legal range 1..15).
- CNT_W, 4, width of the burst counter; must satisfy 2**CNT_W > MAX_BURST.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i is requester i.
- in  input  8  data bits; `in[i]` belongs to requester i.
- out_ready  input  1  consumer accepts `out` this cycle.
- sel  output  3  registered mux select = index of current grantee.
- gnt  output  8  registered one-hot grant; all-zero when idle.
- out  output  1  `in[sel]`, combinational through the shared mux.
- out_valid  output  1  `gnt != 0` and `req[sel]` high.

Behaviour:
- Reset (synchronous, `rst` high at a rising edge) sets:
  - state = IDLE, `gnt` = 8'h00, `sel` = 3'd0, `ptr` = 3'd0, `burst_cnt` = 0.
  - `out_valid` is therefore 0 and `out` = `in[0]`.
  - Reset mid-grant drops the grant on that edge; no transfer completes in that cycle.
- Arbitration function `pick(req, ptr)`: first set bit scanning `ptr`, `ptr`+1, … , 7, 0, … , `ptr`-1 (mod-8 wrap). Undefined when `req` = 0; never used then.
- IDLE state:
  - At an edge with `req` != 0: `sel` <= `pick(req, ptr)`, `gnt` <= one-hot(`sel`), `burst_cnt` <= 0, go to GRANT.
  - Latency: req sampled at edge N → `gnt`/`out_valid` visible after edge N, i.e. one cycle.
- GRANT state:
  - Transfer = `out_valid` & `out_ready` at a rising edge; `burst_cnt` increments on each transfer.
  - `out_ready` low stalls: no count, grant held indefinitely while `req[sel]` stays high.
  - Release condition at an edge, either of:
    - (a) `req[sel]` == 0.
    - (b) a transfer occurs with `burst_cnt` == MAX_BURST-1.
  - On release: `ptr` <= `sel`+1 (wraps 7→0).
    - If `req` != 0, regrant immediately (no idle bubble): `sel` <= `pick(req, sel+1)`, `burst_cnt` <= 0, stay in GRANT.
    - Otherwise `gnt` <= 0, go to IDLE.
  - The released requester may be regranted only if it is the sole requester (rotation guarantees this).
- Simultaneous events:
  - Requests from other requesters arriving during a grant are ignored until release.
  - A grantee dropping `req` in the same cycle as the MAX_BURST transfer is a normal release. It is not counted as a transfer, since `out_valid` was 0.
- `out` is undefined for the consumer when `out_valid` = 0, but still equals `in[sel]`.
- `gnt` is always one-hot or zero; `sel` holds its last value while idle.

Decomposition:
- Shared package `mux_sched_pkg`:
  - State encoding constants ST_IDLE = 1'b0, ST_GRANT = 1'b1.
  - Requester count N_REQ = 8, select width SEL_W = 3.
- One sub-module: `rr_pick`. Combinational; inputs `req[7:0]` and `ptr[2:0]`; outputs `idx[2:0]` and `any`; implements the wrap-around priority scan.
- Data path: reuse the existing 8:1 behavioural mux (`in[sel]`), instantiated inside the scheduler.

Test Plan:
- Reset then `req`=8'h00 for 5 cycles → `gnt`=0, `sel`=0, `out_valid`=0 throughout.
- Single requester:
  - Stimulus: `req`=8'h20, `in`=8'b1111_0001, `out_ready`=1.
  - One cycle later `sel`=5, `gnt`=8'h20, `out`=1, `out_valid`=1.
  - After 4 transfers (MAX_BURST=4): `ptr`=6, and 5 is regranted as sole requester.
- Round-robin:
  - Stimulus: `req`=8'hFF held, `out_ready`=1.
  - Grant order 0,1,2,…,7,0 with each grant lasting exactly 4 cycles and no idle cycle between grants.
- Backpressure: grant to 3, `out_ready`=0 for 10 cycles → `gnt` stays 8'h08, `burst_cnt` frozen; burst resumes when `out_ready` returns to 1.
- Early release and wrap:
  - Stimulus: `req`=8'h81, grant at 7.
  - Drop `req[7]` after 1 transfer → next grant is 0 (wrap); `ptr`=0 after release.
- Reset mid-grant: assert `rst` for 1 cycle while `gnt`=8'h04 → `gnt`=0 and `out_valid`=0 next cycle; next grant search starts from `ptr`=0.
